// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: cache-miss freeze, RAW stalls, branch flush, halt.
// Define PIPELINE_HAZARD_CTRL_FORWARDING_EN to stall only on load-use and forward everything else.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       reg1_num_id,
    input  logic [4:0]       reg2_num_id,
    input  logic             is_reg1_valid_id,
    input  logic             is_reg2_valid_id,
    input  logic [4:0]       dest_reg_num_exe,
    input  logic             reg_write_exe,
    input  logic             mem_to_reg_exe,
    input  logic [4:0]       dest_reg_num_mem,
    input  logic             reg_write_mem,
    input  logic             cache_en_mem,
    input  logic             hit_mem,
    input  logic             branch_taken_id,
    input  logic             halted_wb,
    output logic             freeze_front,
    output logic             bubble_id_exe,
    output logic             freeze_back,
    output logic             flush_if_id,
    output logic             has_reg1_hazard,
    output logic             has_reg2_hazard,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             mem_fill,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StMissWait = 2'd1;
    localparam logic [1:0] StMissFill = 2'd2;
    localparam logic [1:0] StHalted   = 2'd3;

    localparam logic [7:0] MissLoad = 8'(MEM_LATENCY - 1);

    localparam logic [1:0] FwdRegfile = 2'd0;
    localparam logic [1:0] FwdExe     = 2'd1;
    localparam logic [1:0] FwdMem     = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mem_fill_q, mem_fill_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic miss;
    logic rd1_live, rd2_live;
    logic m1_exe, m1_mem, m2_exe, m2_mem;
    logic stall1, stall2;
    logic [1:0] fwd1, fwd2;

    assign miss = cache_en_mem & ~hit_mem;

    // Reads of $0 or of an unused operand can never conflict.
    assign rd1_live = is_reg1_valid_id & (reg1_num_id != 5'd0);
    assign rd2_live = is_reg2_valid_id & (reg2_num_id != 5'd0);

    assign m1_exe = rd1_live & reg_write_exe & (reg1_num_id == dest_reg_num_exe);
    assign m1_mem = rd1_live & reg_write_mem & (reg1_num_id == dest_reg_num_mem);
    assign m2_exe = rd2_live & reg_write_exe & (reg2_num_id == dest_reg_num_exe);
    assign m2_mem = rd2_live & reg_write_mem & (reg2_num_id == dest_reg_num_mem);

`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    // A load in EXE has no data yet; everything else comes off a bypass path.
    assign stall1 = m1_exe & mem_to_reg_exe;
    assign stall2 = m2_exe & mem_to_reg_exe;

    always_comb begin
        fwd1 = FwdRegfile;
        if (m1_exe && !mem_to_reg_exe) begin
            fwd1 = FwdExe;
        end else if (m1_mem) begin
            fwd1 = FwdMem;
        end
    end

    always_comb begin
        fwd2 = FwdRegfile;
        if (m2_exe && !mem_to_reg_exe) begin
            fwd2 = FwdExe;
        end else if (m2_mem) begin
            fwd2 = FwdMem;
        end
    end
`else
    assign stall1 = m1_exe | m1_mem;
    assign stall2 = m2_exe | m2_mem;
    assign fwd1   = FwdRegfile;
    assign fwd2   = FwdRegfile;

    logic unused_mem_to_reg;
    assign unused_mem_to_reg = mem_to_reg_exe;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (miss) begin
                    cnt_d   = MissLoad;
                    state_d = (MissLoad == 8'd0) ? StMissFill : StMissWait;
                end
            end
            StMissWait: begin
                cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = StMissFill;
                end
            end
            StMissFill: state_d = StIdle;
            StHalted:   state_d = StHalted;
            default:    state_d = StIdle;
        endcase
        // Halt wins from anywhere; an in-flight fill is simply dropped.
        if (halted_wb) begin
            state_d = StHalted;
            cnt_d   = 8'd0;
        end
    end

    assign mem_fill_d = (state_d == StMissFill);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            mem_fill_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_fill_q  <= mem_fill_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        freeze_front    = 1'b0;
        freeze_back     = 1'b0;
        bubble_id_exe   = 1'b0;
        flush_if_id     = 1'b0;
        has_reg1_hazard = 1'b0;
        has_reg2_hazard = 1'b0;
        fwd1_sel        = FwdRegfile;
        fwd2_sel        = FwdRegfile;
        if (rst_b) begin
            case (state_q)
                StIdle: begin
                    fwd1_sel = fwd1;
                    fwd2_sel = fwd2;
                    if (miss) begin
                        freeze_front = 1'b1;
                        freeze_back  = 1'b1;
                    end else if (stall1 || stall2) begin
                        freeze_front    = 1'b1;
                        bubble_id_exe   = 1'b1;
                        has_reg1_hazard = stall1;
                        has_reg2_hazard = stall2;
                    end else if (branch_taken_id) begin
                        flush_if_id = 1'b1;
                    end
                end
                StMissWait, StMissFill: begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    fwd1_sel     = fwd1;
                    fwd2_sel     = fwd2;
                end
                default: begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                end
            endcase
        end
    end

    assign mem_fill     = mem_fill_q & rst_b;
    assign stall_cycles = rst_b ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected outputs queued per driven cycle, checked at negedge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [4:0]       reg1_num_id, reg2_num_id;
    logic             is_reg1_valid_id, is_reg2_valid_id;
    logic [4:0]       dest_reg_num_exe, dest_reg_num_mem;
    logic             reg_write_exe, mem_to_reg_exe, reg_write_mem;
    logic             cache_en_mem, hit_mem, branch_taken_id, halted_wb;
    logic             freeze_front, bubble_id_exe, freeze_back, flush_if_id;
    logic             has_reg1_hazard, has_reg2_hazard, mem_fill;
    logic [1:0]       fwd1_sel, fwd2_sel;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct packed {
        logic       ff;
        logic       bub;
        logic       fb;
        logic       fl;
        logic       h1;
        logic       h2;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       fill;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    pipeline_hazard_ctrl #(
        .MEM_LATENCY(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .reg1_num_id     (reg1_num_id),
        .reg2_num_id     (reg2_num_id),
        .is_reg1_valid_id(is_reg1_valid_id),
        .is_reg2_valid_id(is_reg2_valid_id),
        .dest_reg_num_exe(dest_reg_num_exe),
        .reg_write_exe   (reg_write_exe),
        .mem_to_reg_exe  (mem_to_reg_exe),
        .dest_reg_num_mem(dest_reg_num_mem),
        .reg_write_mem   (reg_write_mem),
        .cache_en_mem    (cache_en_mem),
        .hit_mem         (hit_mem),
        .branch_taken_id (branch_taken_id),
        .halted_wb       (halted_wb),
        .freeze_front    (freeze_front),
        .bubble_id_exe   (bubble_id_exe),
        .freeze_back     (freeze_back),
        .flush_if_id     (flush_if_id),
        .has_reg1_hazard (has_reg1_hazard),
        .has_reg2_hazard (has_reg2_hazard),
        .fwd1_sel        (fwd1_sel),
        .fwd2_sel        (fwd2_sel),
        .mem_fill        (mem_fill),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic ff, input logic bub, input logic fb, input logic fl,
                                input logic h1, input logic h2, input logic [1:0] f1,
                                input logic [1:0] f2, input logic fill);
        exp_t e;
        e.ff = ff; e.bub = bub; e.fb = fb; e.fl = fl; e.h1 = h1; e.h2 = h2;
        e.f1 = f1; e.f2 = f2; e.fill = fill;
        return e;
    endfunction

    task automatic clr_in();
        reg1_num_id = 5'd0; reg2_num_id = 5'd0;
        is_reg1_valid_id = 1'b0; is_reg2_valid_id = 1'b0;
        dest_reg_num_exe = 5'd0; reg_write_exe = 1'b0; mem_to_reg_exe = 1'b0;
        dest_reg_num_mem = 5'd0; reg_write_mem = 1'b0;
        cache_en_mem = 1'b0; hit_mem = 1'b1; branch_taken_id = 1'b0; halted_wb = 1'b0;
    endtask

    // Inputs are already driven for this cycle; queue what must appear and check it at negedge.
    task automatic step(input string name, input exp_t e);
        exp_t x;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        check_eq({name, ".freeze_front"}, 32'(freeze_front), 32'(x.ff));
        check_eq({name, ".bubble_id_exe"}, 32'(bubble_id_exe), 32'(x.bub));
        check_eq({name, ".freeze_back"}, 32'(freeze_back), 32'(x.fb));
        check_eq({name, ".flush_if_id"}, 32'(flush_if_id), 32'(x.fl));
        check_eq({name, ".has_reg1_hazard"}, 32'(has_reg1_hazard), 32'(x.h1));
        check_eq({name, ".has_reg2_hazard"}, 32'(has_reg2_hazard), 32'(x.h2));
        check_eq({name, ".fwd1_sel"}, 32'(fwd1_sel), 32'(x.f1));
        check_eq({name, ".fwd2_sel"}, 32'(fwd2_sel), 32'(x.f2));
        check_eq({name, ".mem_fill"}, 32'(mem_fill), 32'(x.fill));
        check_eq({name, ".stall_cycles"}, 32'(stall_cycles), exp_cnt);
        if (x.ff) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    exp_t e0, efrz, efill, eload1;

    initial begin
        e0     = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        efrz   = mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        efill  = mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 1);
        eload1 = mk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0);

        // Reset held with every trigger active.
        clr_in();
        rst_b = 1'b0;
        cache_en_mem = 1'b1; hit_mem = 1'b0; branch_taken_id = 1'b1;
        reg1_num_id = 5'd8; is_reg1_valid_id = 1'b1;
        dest_reg_num_exe = 5'd8; reg_write_exe = 1'b1;
        @(posedge clk);
        #1;
        step("rst0", e0);
        step("rst1", e0);
        rst_b = 1'b1;
        clr_in();
        step("idle", e0);

        // Cache miss, latency 4: 5 frozen cycles, fill on the last.
        cache_en_mem = 1'b1; hit_mem = 1'b0;
        step("miss_idle", efrz);
        step("miss_w1", efrz);
        step("miss_w2", efrz);
        step("miss_w3", efrz);
        step("miss_fill", efill);
        hit_mem = 1'b1;
        step("miss_done", e0);
        check_eq("miss_stall_total", 32'(stall_cycles), 32'd5);
        clr_in();

        // Load-use on rs.
        dest_reg_num_exe = 5'd8; reg_write_exe = 1'b1; mem_to_reg_exe = 1'b1;
        reg1_num_id = 5'd8; is_reg1_valid_id = 1'b1;
        step("lu_exe", eload1);
        reg_write_exe = 1'b0; mem_to_reg_exe = 1'b0; dest_reg_num_exe = 5'd0;
        dest_reg_num_mem = 5'd8; reg_write_mem = 1'b1;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        step("lu_mem", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0));
`else
        step("lu_mem", eload1);
`endif
        reg_write_mem = 1'b0;
        step("lu_wb", e0);
        clr_in();

        // ALU producer in EXE read as rt, then both operands, then MEM only.
        dest_reg_num_exe = 5'd9; reg_write_exe = 1'b1;
        reg2_num_id = 5'd9; is_reg2_valid_id = 1'b1;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        step("alu_rt", mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0));
`else
        step("alu_rt", mk(1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
`endif
        reg1_num_id = 5'd9; is_reg1_valid_id = 1'b1;
        dest_reg_num_mem = 5'd9; reg_write_mem = 1'b1;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        step("alu_both", mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0));
`else
        step("alu_both", mk(1, 1, 0, 0, 1, 1, 2'd0, 2'd0, 0));
`endif
        reg_write_exe = 1'b0;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        step("mem_both", mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 0));
`else
        step("mem_both", mk(1, 1, 0, 0, 1, 1, 2'd0, 2'd0, 0));
`endif
        is_reg1_valid_id = 1'b0; is_reg2_valid_id = 1'b0;
        step("not_read", e0);
        clr_in();

        // $0 never conflicts.
        dest_reg_num_exe = 5'd0; reg_write_exe = 1'b1;
        dest_reg_num_mem = 5'd0; reg_write_mem = 1'b1;
        reg1_num_id = 5'd0; is_reg1_valid_id = 1'b1;
        step("zero_reg", e0);
        clr_in();

        // Branch during a load-use stall: flush waits for the stall to clear.
        dest_reg_num_exe = 5'd8; reg_write_exe = 1'b1; mem_to_reg_exe = 1'b1;
        reg1_num_id = 5'd8; is_reg1_valid_id = 1'b1; branch_taken_id = 1'b1;
        step("br_stall", eload1);
        clr_in();
        branch_taken_id = 1'b1;
        step("br_flush", mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0));
        branch_taken_id = 1'b0;
        step("br_after", e0);

        // Miss beats a hazard; no bubble while the back end is frozen.
        cache_en_mem = 1'b1; hit_mem = 1'b0;
        dest_reg_num_exe = 5'd8; reg_write_exe = 1'b1; mem_to_reg_exe = 1'b1;
        reg1_num_id = 5'd8; is_reg1_valid_id = 1'b1; branch_taken_id = 1'b1;
        step("mh_idle", efrz);
        clr_in();
        step("mh_w1", efrz);
        step("mh_w2", efrz);
        step("mh_w3", efrz);
        step("mh_fill", efill);
        step("mh_done", e0);

        // Still missing after the fill: sequence restarts.
        cache_en_mem = 1'b1; hit_mem = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step("rs_idle", efrz);
            step("rs_w1", efrz);
            step("rs_w2", efrz);
            step("rs_w3", efrz);
            step("rs_fill", efill);
        end
        hit_mem = 1'b1;
        step("rs_done", e0);

        // Halt mid-miss: fill dropped, freeze held, counter keeps counting.
        cache_en_mem = 1'b1; hit_mem = 1'b0;
        step("hm_idle", efrz);
        cache_en_mem = 1'b0; halted_wb = 1'b1;
        step("hm_w1", efrz);
        halted_wb = 1'b0;
        cache_en_mem = 1'b1; branch_taken_id = 1'b1;
        dest_reg_num_exe = 5'd8; reg_write_exe = 1'b1;
        reg1_num_id = 5'd8; is_reg1_valid_id = 1'b1;
        for (int h = 0; h < 20; h++) begin
            step("halted", efrz);
        end
        check_eq("halt_stall_total", 32'(stall_cycles), exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
